// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, the per-group stage-1 record and the tag
// forming helper for the block-select to tag encoder (encoder_128_7).
package cache_pkg;

  localparam int TAG_W     = 7;
  localparam int BLOCK_W   = 128;
  localparam int GRP_W     = 16;
  localparam int N_GRP     = 8;
  localparam int IDX_W     = 4;
  localparam int GRP_SEL_W = 3;

  // Stage-1 summary of one 16-bit group: any bit set, two or more bits set,
  // and the index of the lowest set bit inside the group.
  typedef struct packed {
    logic             any;
    logic             multi;
    logic [IDX_W-1:0] idx;
  } s1_grp_t;

  // Tag code for the lowest set bit at {grp,idx}; tag 0 is reserved for "none".
  function automatic logic [TAG_W-1:0] make_tag(input logic [GRP_SEL_W-1:0] grp,
                                                 input logic [IDX_W-1:0]     idx);
    return {grp, idx} + 7'd1;
  endfunction

endpackage

// File: rtl/encoder_16_4.sv
// encoder_16_4: combinational lowest-set-bit encoder for one 16-bit group.
// Ports:
//   vec  in  16  group slice of the block-select vector
//   grp  out     {any, multi, idx}; idx is 0 when no bit is set
// Build option ENCODER_ONEHOT_CHECK_EN: when undefined, multi is tied low and
// the multi-hot detector is not built.
module encoder_16_4
  import cache_pkg::*;
(
  input  logic [GRP_W-1:0] vec,
  output s1_grp_t          grp
);

  // Lowest set bit wins: scan from the top so the last hit is the lowest.
  always_comb begin
    grp     = '{any: 1'b0, multi: 1'b0, idx: 4'd0};
    grp.any = |vec;
    for (int i = GRP_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        grp.idx = 4'(i);
      end else begin
        grp.idx = grp.idx;
      end
    end
`ifdef ENCODER_ONEHOT_CHECK_EN
    // Clearing the lowest set bit leaves something only if two or more were set.
    grp.multi = |(vec & (vec - 16'd1));
`else
    grp.multi = 1'b0;
`endif
  end

endmodule

// File: rtl/encoder_128_7.sv
// encoder_128_7: two-stage pipelined 128-bit block-select to 7-bit tag encoder.
// All-zero -> tag 0; lowest set bit k (k <= 126) -> tag k+1. Bit 127 has no
// code: alone it gives tag 0 with err, alongside lower bits it is ignored.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    request handshake, block = 128-bit select vector
//   out_valid/out_ready  result handshake, tag = 7-bit code, err = illegal input
// Parameter ERR_STICKY: 1 keeps err high from its first assertion until reset.
// Build option ENCODER_ONEHOT_CHECK_EN: when defined, err also flags multi-hot.
module encoder_128_7
  import cache_pkg::*;
#(
  parameter bit ERR_STICKY = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] block,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TAG_W-1:0]   tag,
  output logic               err
);

  logic [GRP_W-1:0] grp_vec_s [N_GRP];
  s1_grp_t          enc_s     [N_GRP];

  logic             init_done_q;
  logic             s1_valid_q, s1_valid_d;
  s1_grp_t          s1_grp_q  [N_GRP];
  s1_grp_t          s1_grp_d  [N_GRP];
  logic             s1_b127_q, s1_b127_d;
  logic             out_valid_q, out_valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d;

  logic             s2_advance_s, s1_advance_s, in_fire_s;
  logic [TAG_W-1:0] sel_tag_s;
  logic             any_hit_s, new_err_s;

  // Slice the block into groups; bit 127 is masked so it never yields a tag.
  always_comb begin
    for (int g = 0; g < N_GRP; g++) begin
      grp_vec_s[g] = block[g*GRP_W +: GRP_W];
    end
    grp_vec_s[N_GRP-1][GRP_W-1] = 1'b0;
  end

  for (genvar g = 0; g < N_GRP; g++) begin : g_enc
    encoder_16_4 u_enc (
      .vec (grp_vec_s[g]),
      .grp (enc_s[g])
    );
  end

  // S2 drains or is empty; S1 may only move into S2 under that condition.
  always_comb begin
    s2_advance_s = !out_valid_q || out_ready;
    s1_advance_s = s1_valid_q && s2_advance_s;
    in_ready     = init_done_q && (!s1_valid_q || s1_advance_s);
    in_fire_s    = in_valid && in_ready;
  end

  // Stage-1 next state: capture group summaries on accept, empty on advance.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_grp_d   = s1_grp_q;
    s1_b127_d  = s1_b127_q;
    if (in_fire_s) begin
      s1_valid_d = 1'b1;
      s1_grp_d   = enc_s;
      s1_b127_d  = block[BLOCK_W-1];
    end else if (s1_advance_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage-2 decode: lowest non-empty group wins, then legality of the input.
  always_comb begin
    logic       multi_v;
`ifdef ENCODER_ONEHOT_CHECK_EN
    logic [3:0] cnt_v;
    cnt_v = {3'd0, s1_b127_q};
`endif
    sel_tag_s = 7'd0;
    any_hit_s = 1'b0;
    multi_v   = 1'b0;
    for (int g = N_GRP - 1; g >= 0; g--) begin
      if (s1_grp_q[g].any) begin
        sel_tag_s = make_tag(3'(g), s1_grp_q[g].idx);
        any_hit_s = 1'b1;
      end else begin
        sel_tag_s = sel_tag_s;
      end
      // Multi flags are constant 0 unless the one-hot checker is built.
      multi_v = multi_v | s1_grp_q[g].multi;
`ifdef ENCODER_ONEHOT_CHECK_EN
      cnt_v = cnt_v + {3'd0, s1_grp_q[g].any};
`endif
    end
`ifdef ENCODER_ONEHOT_CHECK_EN
    // Bits in two different groups (bit 127 counted as its own) are multi-hot.
    multi_v = multi_v | (cnt_v >= 4'd2);
`endif
    new_err_s = (s1_b127_q && !any_hit_s) || multi_v;
  end

  // Stage-2 next state: load on advance, otherwise hold tag/err stable.
  always_comb begin
    out_valid_d = out_valid_q;
    tag_d       = tag_q;
    err_d       = err_q;
    if (s2_advance_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        tag_d = sel_tag_s;
        err_d = ERR_STICKY ? (err_q | new_err_s) : new_err_s;
      end else begin
        tag_d = tag_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Holds in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= 1'b1;
    end
  end

  // Pipeline registers for both stages; reset discards in-flight requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_grp_q    <= '{default: '{any: 1'b0, multi: 1'b0, idx: 4'd0}};
      s1_b127_q   <= 1'b0;
      out_valid_q <= 1'b0;
      tag_q       <= 7'd0;
      err_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_grp_q    <= s1_grp_d;
      s1_b127_q   <= s1_b127_d;
      out_valid_q <= out_valid_d;
      tag_q       <= tag_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign tag       = tag_q;
  assign err       = err_q;

endmodule

// File: tb/tb_encoder_128_7.sv
module tb_encoder_128_7;
  import cache_pkg::*;

`ifdef ENCODER_ONEHOT_CHECK_EN
  localparam logic OH = 1'b1;
`else
  localparam logic OH = 1'b0;
`endif

  logic         clk, rst_n, in_valid, out_ready;
  logic [127:0] block;
  logic         in_ready, out_valid, err;
  logic [6:0]   tag;
  logic         in_ready_s, out_valid_s, err_s;
  logic [6:0]   tag_s;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  logic sticky_seen = 1'b0;

  typedef struct { logic [6:0] tag; logic err; int due; } exp_t;
  exp_t q[$];

  encoder_128_7 #(.ERR_STICKY(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .block(block), .out_valid(out_valid), .out_ready(out_ready),
    .tag(tag), .err(err));

  encoder_128_7 #(.ERR_STICKY(1'b1)) u_dut_sticky (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .block(block), .out_valid(out_valid_s), .out_ready(out_ready),
    .tag(tag_s), .err(err_s));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check outputs/handshake, advance to next negedge.
  task automatic cyc(input logic v, input logic [127:0] b, input logic ord,
                     input logic exp_acc, input logic [6:0] etag, input logic eerr);
    exp_t h;
    in_valid  = v;
    block     = b;
    out_ready = ord;
    #1;
    chk("valid_match", 32'(out_valid_s), 32'(out_valid));
    if (q.size() > 0 && q[0].due <= cyc_n) chk("latency_valid", 32'(out_valid), 32'd1);
    if (out_valid === 1'b1) begin
      chk("no_stale", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        h = q[0];
        chk("tag", 32'(tag), 32'(h.tag));
        chk("err", 32'(err), 32'(h.err));
        chk("tag_sticky", 32'(tag_s), 32'(h.tag));
        chk("err_sticky", 32'(err_s), 32'(sticky_seen | h.err));
        if (ord) begin
          void'(q.pop_front());
          sticky_seen = sticky_seen | h.err;
        end
      end
    end
    if (v) begin
      chk("in_ready", 32'(in_ready), 32'(exp_acc));
      chk("in_ready_sticky", 32'(in_ready_s), 32'(exp_acc));
      if (in_ready === 1'b1) q.push_back('{tag: etag, err: eerr, due: cyc_n + 2});
    end
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic drain();
    repeat (4) cyc(1'b0, 128'd0, 1'b1, 1'b0, 7'd0, 1'b0);
    chk("drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; block = 128'd0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_tag", 32'(tag), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready_pre_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("in_ready_post_edge", 32'(in_ready), 32'd1);

    // Zero then single-bit sweep, back-to-back.
    cyc(1'b1, 128'd0, 1'b1, 1'b1, 7'd0, 1'b0);
    for (int k = 0; k < 127; k++) cyc(1'b1, 128'd1 << k, 1'b1, 1'b1, 7'(k + 1), 1'b0);
    drain();

    // Backpressure: out_ready low for 5 cycles, 4 requests.
    cyc(1'b1, 128'd1 << 10, 1'b0, 1'b1, 7'd11, 1'b0);
    cyc(1'b1, 128'd1 << 40, 1'b0, 1'b1, 7'd41, 1'b0);
    cyc(1'b1, 128'd1 << 99, 1'b0, 1'b0, 7'd100, 1'b0);
    cyc(1'b1, 128'd1 << 99, 1'b0, 1'b0, 7'd100, 1'b0);
    cyc(1'b1, 128'd1 << 99, 1'b0, 1'b0, 7'd100, 1'b0);
    cyc(1'b1, 128'd1 << 99, 1'b1, 1'b1, 7'd100, 1'b0);
    cyc(1'b1, 128'd1 << 126, 1'b1, 1'b1, 7'd127, 1'b0);
    drain();

    // Bit 127, multi-hot and sticky error.
    cyc(1'b1, 128'd1 << 127, 1'b1, 1'b1, 7'd0, 1'b1);
    cyc(1'b1, (128'd1 << 127) | (128'd1 << 4), 1'b1, 1'b1, 7'd5, OH);
    cyc(1'b1, 128'h0000_0000_0000_0000_0000_0001_0000_0100, 1'b1, 1'b1, 7'd9, OH);
    cyc(1'b1, 128'h3, 1'b1, 1'b1, 7'd1, OH);
    cyc(1'b1, 128'd1 << 3, 1'b1, 1'b1, 7'd4, 1'b0);
    drain();

    // Async reset with both stages full.
    cyc(1'b1, 128'd1 << 20, 1'b0, 1'b1, 7'd21, 1'b0);
    cyc(1'b1, 128'd1 << 21, 1'b0, 1'b1, 7'd22, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_tag", 32'(tag), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_out_valid_sticky", 32'(out_valid_s), 32'd0);
    chk("mid_rst_err_sticky", 32'(err_s), 32'd0);
    q.delete();
    sticky_seen = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_in_ready_pre_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    repeat (3) cyc(1'b0, 128'd0, 1'b1, 1'b0, 7'd0, 1'b0);
    cyc(1'b1, 128'd1 << 64, 1'b1, 1'b1, 7'd65, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
